// File: rtl/classify_pkg.sv
`default_nettype none
// ============================================================================
// Module      : classify_pkg
// Description : Shared types and constants for the classify_sched argmax
//               scheduler: FSM state enum, default score width / class count,
//               index-width derivation and the Index reset constant.
// Revision    : 1.0 - initial release
// ============================================================================
package classify_pkg;

  localparam int DEFAULT_NUM_SIZE  = 26;
  localparam int DEFAULT_NUM_CLASS = 10;

  // Index width for a given class count; never narrower than one bit.
  function automatic int idx_width(input int num_class);
    return (num_class > 2) ? $clog2(num_class) : 1;
  endfunction

  localparam int DEFAULT_IDX_W = idx_width(DEFAULT_NUM_CLASS);

  // Reset value of Index: all ones, which is never a legal class at the
  // default class count.
  localparam logic [DEFAULT_IDX_W-1:0] INDEX_RESET = '1;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    RESULT  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/classify_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : classify_sched_if
// Description : Score stream and result port of classify_sched.
//               slave  : the scheduler side
//               master : the neuron array / result consumer side
//   ScoreValid/ScoreReady/Score/ScoreLast : score beats, one per class
//   IndexValid/IndexReady/Index           : winning class handshake
//   ErrLen     : one-cycle frame-length error pulse
//   FrameCount : delivered results (wraps at 2^16)
//   MaxScore   : winning score, present only with CLASSIFY_MAXVAL_EN
// Macro       : CLASSIFY_MAXVAL_EN
// Revision    : 1.0 - initial release
// ============================================================================
interface classify_sched_if
  import classify_pkg::*;
#(
  parameter int NUM_SIZE  = DEFAULT_NUM_SIZE,
  parameter int NUM_CLASS = DEFAULT_NUM_CLASS,
  parameter int IDX_W     = idx_width(NUM_CLASS)
) ();

  logic                       ScoreValid;
  logic                       ScoreReady;
  logic signed [NUM_SIZE-1:0] Score;
  logic                       ScoreLast;
  logic                       IndexValid;
  logic                       IndexReady;
  logic [IDX_W-1:0]           Index;
  logic                       ErrLen;
  logic [15:0]                FrameCount;
`ifdef CLASSIFY_MAXVAL_EN
  logic signed [NUM_SIZE-1:0] MaxScore;
`endif

  modport slave (
    input  ScoreValid, Score, ScoreLast, IndexReady,
    output ScoreReady, IndexValid, Index, ErrLen, FrameCount
`ifdef CLASSIFY_MAXVAL_EN
    , MaxScore
`endif
  );

  modport master (
    output ScoreValid, Score, ScoreLast, IndexReady,
    input  ScoreReady, IndexValid, Index, ErrLen, FrameCount
`ifdef CLASSIFY_MAXVAL_EN
    , MaxScore
`endif
  );

endinterface
`default_nettype wire

// File: rtl/argmax_step.sv
`default_nettype none
// ============================================================================
// Module      : argmax_step
// Description : Combinational compare-and-select for one argmax step. The new
//               score replaces the running maximum only when strictly greater
//               (signed), so ties keep the earlier index.
//   i_cur_max / i_cur_idx     : running maximum and its class index
//   i_new_score / i_new_idx   : incoming score and its class index
//   o_nxt_max / o_nxt_idx     : updated maximum and index
// Revision    : 1.0 - initial release
// ============================================================================
module argmax_step #(
  parameter int NUM_SIZE = 26,
  parameter int IDX_W    = 4
) (
  input  wire logic signed [NUM_SIZE-1:0] i_cur_max,
  input  wire logic        [IDX_W-1:0]    i_cur_idx,
  input  wire logic signed [NUM_SIZE-1:0] i_new_score,
  input  wire logic        [IDX_W-1:0]    i_new_idx,
  output logic signed      [NUM_SIZE-1:0] o_nxt_max,
  output logic             [IDX_W-1:0]    o_nxt_idx
);

  logic w_take;

  assign w_take    = (i_new_score > i_cur_max);
  assign o_nxt_max = w_take ? i_new_score : i_cur_max;
  assign o_nxt_idx = w_take ? i_new_idx   : i_cur_idx;

endmodule
`default_nettype wire

// File: rtl/classify_sched.sv
`default_nettype none
// ============================================================================
// Module      : classify_sched
// Description : Sequential argmax scheduler. Takes NUM_CLASS signed scores per
//               frame (one per beat), tracks the running maximum and presents
//               the winning class on a valid/ready result port.
//   Clk         : rising-edge clock
//   GlobalReset : asynchronous active-low reset
//   Flush       : synchronous abort of the current frame / pending result
//   bus         : classify_sched_if.slave (score stream, result, status)
// Macro       : CLASSIFY_MAXVAL_EN adds the registered MaxScore output
// Revision    : 1.0 - initial release
// ============================================================================
module classify_sched
  import classify_pkg::*;
#(
  parameter int NUM_SIZE  = DEFAULT_NUM_SIZE,
  parameter int NUM_CLASS = DEFAULT_NUM_CLASS
) (
  input  wire logic        Clk,
  input  wire logic        GlobalReset,
  input  wire logic        Flush,
  classify_sched_if.slave  bus
);

  localparam int               IDX_W       = idx_width(NUM_CLASS);
  localparam logic [IDX_W-1:0] c_idx_reset = '1;
  localparam logic [IDX_W-1:0] c_last_beat = IDX_W'(NUM_CLASS - 1);

  state_t                     r_state,        w_state_nxt;
  logic        [IDX_W-1:0]    r_cnt,          w_cnt_nxt;
  logic signed [NUM_SIZE-1:0] r_max,          w_max_nxt;
  logic        [IDX_W-1:0]    r_idx,          w_idx_nxt;
  logic                       r_score_ready,  w_score_ready_nxt;
  logic                       r_index_valid,  w_index_valid_nxt;
  logic        [IDX_W-1:0]    r_index,        w_index_nxt;
  logic                       r_err_len,      w_err_len_nxt;
  logic        [15:0]         r_frame_count,  w_frame_count_nxt;
`ifdef CLASSIFY_MAXVAL_EN
  logic signed [NUM_SIZE-1:0] r_max_score,    w_max_score_nxt;
`endif

  logic                       w_beat;
  logic signed [NUM_SIZE-1:0] w_step_max;
  logic        [IDX_W-1:0]    w_step_idx;
  logic signed [NUM_SIZE-1:0] w_sel_max;
  logic        [IDX_W-1:0]    w_sel_idx;

  assign w_beat = bus.ScoreValid & r_score_ready;

  argmax_step #(
    .NUM_SIZE (NUM_SIZE),
    .IDX_W    (IDX_W)
  ) u_argmax_step (
    .i_cur_max   (r_max),
    .i_cur_idx   (r_idx),
    .i_new_score (bus.Score),
    .i_new_idx   (r_cnt),
    .o_nxt_max   (w_step_max),
    .o_nxt_idx   (w_step_idx)
  );

  // Beat 0 seeds the running max unconditionally; whatever the previous
  // frame left in r_max/r_idx must not take part in the compare.
  assign w_sel_max = (r_cnt == '0) ? bus.Score : w_step_max;
  assign w_sel_idx = (r_cnt == '0) ? '0        : w_step_idx;

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_max_nxt         = r_max;
    w_idx_nxt         = r_idx;
    w_index_valid_nxt = r_index_valid;
    w_index_nxt       = r_index;
    w_err_len_nxt     = 1'b0;
    w_frame_count_nxt = r_frame_count;
`ifdef CLASSIFY_MAXVAL_EN
    w_max_score_nxt   = r_max_score;
`endif

    if (Flush) begin
      // Abort wins over any beat or result handshake in the same cycle.
      w_state_nxt       = COLLECT;
      w_cnt_nxt         = '0;
      w_index_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_beat) begin
            w_max_nxt = w_sel_max;
            w_idx_nxt = w_sel_idx;
            if (r_cnt == c_last_beat) begin
              // Full frame: the result is delivered even if ScoreLast is
              // missing; the length error is flagged alongside it.
              w_state_nxt       = RESULT;
              w_cnt_nxt         = '0;
              w_index_valid_nxt = 1'b1;
              w_index_nxt       = w_sel_idx;
              w_err_len_nxt     = ~bus.ScoreLast;
`ifdef CLASSIFY_MAXVAL_EN
              w_max_score_nxt   = w_sel_max;
`endif
            end else if (bus.ScoreLast) begin
              // Short frame: drop it and start over.
              w_cnt_nxt     = '0;
              w_err_len_nxt = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + IDX_W'(1);
            end
          end
        end
        RESULT: begin
          if (bus.IndexReady) begin
            w_state_nxt       = COLLECT;
            w_index_valid_nxt = 1'b0;
            w_frame_count_nxt = r_frame_count + 16'd1;
          end
        end
        default: begin
          w_state_nxt = COLLECT;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    w_score_ready_nxt = (w_state_nxt == COLLECT);
  end

  always_ff @(posedge Clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      r_state       <= COLLECT;
      r_cnt         <= '0;
      r_max         <= '0;
      r_idx         <= '0;
      r_score_ready <= 1'b0;
      r_index_valid <= 1'b0;
      r_index       <= c_idx_reset;
      r_err_len     <= 1'b0;
      r_frame_count <= '0;
`ifdef CLASSIFY_MAXVAL_EN
      r_max_score   <= '0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_max         <= w_max_nxt;
      r_idx         <= w_idx_nxt;
      r_score_ready <= w_score_ready_nxt;
      r_index_valid <= w_index_valid_nxt;
      r_index       <= w_index_nxt;
      r_err_len     <= w_err_len_nxt;
      r_frame_count <= w_frame_count_nxt;
`ifdef CLASSIFY_MAXVAL_EN
      r_max_score   <= w_max_score_nxt;
`endif
    end
  end

  assign bus.ScoreReady = r_score_ready;
  assign bus.IndexValid = r_index_valid;
  assign bus.Index      = r_index;
  assign bus.ErrLen     = r_err_len;
  assign bus.FrameCount = r_frame_count;
`ifdef CLASSIFY_MAXVAL_EN
  assign bus.MaxScore   = r_max_score;
`endif

endmodule
`default_nettype wire

// File: doc/classify_sched.md
# classify_sched

Sequential argmax scheduler for the classifier output stage. It accepts the NUM_CLASS signed class scores of one frame as a valid/ready stream, one per beat, and tracks the running maximum and its index. It presents the winning class index on a valid/ready result port and counts delivered results. It sits between the output-layer neuron array and the downstream result consumer.

## Interface
- NUM_SIZE, 26, score width (signed two's complement)
- NUM_CLASS, 10, scores per frame (≥2)
- Clk  in  1  single clock, rising edge
- GlobalReset  in  1  asynchronous, active-low reset
- Flush  in  1  synchronous frame abort
- ScoreValid  in  1  Score beat valid
- ScoreReady  out  1  block can accept a beat
- Score  in  NUM_SIZE  signed class score, class order 0..NUM_CLASS-1
- ScoreLast  in  1  marks final beat of frame
- IndexValid  out  1  result valid
- IndexReady  in  1  consumer accepts result
- Index  out  IDX_W  winning class; IDX_W = $clog2(NUM_CLASS) (4 at default)
- ErrLen  out  1  one-cycle pulse on frame-length error
- FrameCount  out  16  results delivered, wraps at 2^16
- MaxScore  out  NUM_SIZE  winning score (only with CLASSIFY_MAXVAL_EN)

## Operation
- States: COLLECT and RESULT. Reset state is COLLECT with beat counter 0.
- Accept a beat only when ScoreValid and ScoreReady are both high.
- ScoreReady is registered. It is high only in COLLECT.
- Beat 0: load running max = Score and running index = 0.
- Beat k > 0: replace max/index only if $signed(Score) > $signed(max). Strict compare, so on a tie the earliest index wins.
- Beat NUM_CLASS-1 accepted: latch Index (and MaxScore) from the final compare, enter RESULT, counter → 0. If ScoreLast is low on this beat, pulse ErrLen but still produce the result.
- ScoreLast on beat k < NUM_CLASS-1: pulse ErrLen, discard the partial frame, counter → 0, stay in COLLECT, produce no result.
- RESULT: IndexValid high. Index and MaxScore are held stable until IndexReady. On handshake: FrameCount+1 (wraps), go to COLLECT.
- Flush: drops the partial frame or pending result (no FrameCount increment), next state COLLECT with counter 0. Flush beats a handshake or a beat in the same cycle.
- Reset values: ScoreReady 0, IndexValid 0, Index all-ones (4'hF), ErrLen 0, FrameCount 0, MaxScore 0, internal max 0.
- GlobalReset assertion mid-frame or mid-result forces these values immediately (asynchronous). The partial frame is lost.

## Timing
- All outputs are registered.
- ScoreReady rises on the first Clk edge after GlobalReset is released.
- Final beat accepted at edge t: IndexValid, Index, ScoreReady=0 visible after t. Latency is 1 cycle.
- Handshake at edge t: IndexValid=0 and ScoreReady=1 after t, so a new beat can be accepted at t+1.
- Best-case throughput is NUM_CLASS+1 cycles per frame.
- ErrLen is high for exactly the cycle after the offending beat.

## Configuration
- CLASSIFY_MAXVAL_EN defined: MaxScore port present. It is registered and updated together with Index.
- CLASSIFY_MAXVAL_EN undefined: MaxScore port and its output register are absent. The internal running-max register remains. All other behaviour is identical.

## Structure
- Package classify_pkg holds:
  - state enum typedef (COLLECT, RESULT)
  - NUM_SIZE and NUM_CLASS defaults
  - IDX_W derivation
  - Index reset constant (all ones)
- Sub-module argmax_step: purely combinational compare-and-select. Inputs are running max/index and the new score/index. Outputs are the next max/index using a signed strict-greater compare.
- The FSM, beat counter and FrameCount live in classify_sched.

## Test plan
- Frame with class 7 = 100, all others −5, ScoreLast on beat 9, IndexReady=1 → Index=7 one cycle after beat 9, FrameCount=1.
- Ties and signedness: class 2 = 50, class 5 = 50, class 4 = 26'h2000000 (most negative), rest −1 → Index=2. With CLASSIFY_MAXVAL_EN, MaxScore=50.
- All negative: class 0 = −3, others −1000..−10 → Index=0.
- Backpressure: IndexReady low 5 cycles → Index held, ScoreReady=0, no beats taken. FrameCount increments only on the handshake cycle.
- ScoreLast on beat 4 → ErrLen pulse, no IndexValid. Next full frame (class 9 max) → Index=9. Beat 9 without ScoreLast → ErrLen pulse plus a valid result.
- GlobalReset low after 6 beats → Index=4'hF, IndexValid=0, FrameCount=0. Flush during RESULT → result dropped. A following fresh frame classifies correctly.
